// File: rtl/rf_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// rf_writeback_arbiter
//   Write-side initiator for the 32x32 register file. ALU results and buffered
//   load returns are merged into at most one registered write per cycle.
//   Load returns always pass through a small FIFO. ALU traffic normally has
//   priority. The FIFO head is forced out when the FIFO is full, or when the
//   head has waited MAX_WAIT cycles. Writes to x0 are consumed but never
//   issued, so RegWriteEn stays low for them.
//
// Ports
//   clk, rst                   clock (posedge), async active-high reset
//   alu_valid/alu_ready        ALU result handshake; alu_rd/alu_data carry it
//   ld_valid/ld_ready          load-return handshake; ld_rd/ld_data carry it
//   WriteData/WriteAddress     registered regfile write port (sampled at negedge)
//   RegWriteEn                 registered regfile write enable
//   fifo_count                 current load FIFO occupancy
//   query_rd/query_pending     (WB_PENDING_EN only) load-use hazard query
//
// Configuration macro
//   WB_PENDING_EN  adds query_rd/query_pending. query_pending is high when a
//                  valid FIFO entry targets query_rd (x0 never matches).
// -----------------------------------------------------------------------------
module rf_writeback_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int LD_DEPTH = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_valid,
  output logic                        alu_ready,
  input  logic [AW-1:0]               alu_rd,
  input  logic [DW-1:0]               alu_data,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [AW-1:0]               ld_rd,
  input  logic [DW-1:0]               ld_data,
  output logic [DW-1:0]               WriteData,
  output logic [AW-1:0]               WriteAddress,
  output logic                        RegWriteEn,
  output logic [$clog2(LD_DEPTH):0]   fifo_count
`ifdef WB_PENDING_EN
  ,
  input  logic [AW-1:0]               query_rd,
  output logic                        query_pending
`endif
);

  localparam int PW = $clog2(LD_DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(LD_DEPTH);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  // FIFO storage and control state
  logic [AW-1:0] fifo_rd_q   [LD_DEPTH];
  logic [DW-1:0] fifo_data_q [LD_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] wait_q, wait_d;

  // Registered write port
  logic [DW-1:0] wdata_q, wdata_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          wen_q, wen_d;

  logic          fifo_full_s;
  logic          fifo_nonempty_s;
  logic          force_s;
  logic          alu_fire_s;
  logic          pop_s;
  logic          push_s;
  logic [AW-1:0] head_rd_s;
  logic [DW-1:0] head_data_s;

  // Arbitration decisions, derived only from registered state plus valids.
  always_comb begin
    fifo_full_s     = (count_q == FULL_CNT);
    fifo_nonempty_s = (count_q != '0);
    // A full FIFO, or a head that has waited long enough, wins over the ALU.
    force_s         = fifo_full_s | (fifo_nonempty_s & (wait_q == WAIT_MAX));
    alu_fire_s      = alu_valid & ~force_s;
    // force implies nonempty, so an empty FIFO is never popped.
    pop_s           = force_s | (~alu_valid & fifo_nonempty_s);
    // The start-of-cycle full flag gates the push, even while popping.
    push_s          = ld_valid & ~fifo_full_s;
    head_rd_s       = fifo_rd_q[rd_ptr_q];
    head_data_s     = fifo_data_q[rd_ptr_q];
  end

  assign alu_ready    = ~force_s;
  assign ld_ready     = ~fifo_full_s;
  assign WriteData    = wdata_q;
  assign WriteAddress = waddr_q;
  assign RegWriteEn   = wen_q;
  assign fifo_count   = count_q;

  // Next-state computation for the FIFO control, the wait counter and the write port.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wait_d   = wait_q;
    wdata_d  = wdata_q;
    waddr_d  = waddr_q;
    wen_d    = 1'b0;

    if (push_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (!push_s && pop_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Age of the current head. It restarts whenever the head changes or the FIFO is empty.
    if (!fifo_nonempty_s || pop_s) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + WW'(1);
    end else begin
      wait_d = wait_q;
    end

    if (alu_fire_s) begin
      wdata_d = alu_data;
      waddr_d = alu_rd;
      wen_d   = (alu_rd != '0);
    end else if (pop_s) begin
      wdata_d = head_data_s;
      waddr_d = head_rd_s;
      wen_d   = (head_rd_s != '0);
    end else begin
      wen_d   = 1'b0;
    end
  end

  // State registers. An async reset drops all pending entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
      wdata_q  <= '0;
      waddr_q  <= '0;
      wen_q    <= 1'b0;
      for (int i = 0; i < LD_DEPTH; i++) begin
        fifo_rd_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
      wdata_q  <= wdata_d;
      waddr_q  <= waddr_d;
      wen_q    <= wen_d;
      if (push_s) begin
        fifo_rd_q[wr_ptr_q]   <= ld_rd;
        fifo_data_q[wr_ptr_q] <= ld_data;
      end
    end
  end

`ifdef WB_PENDING_EN
  logic [PW-1:0] occ_off_s;

  // Hazard query. Slot i is live when its distance from the head is below the occupancy.
  always_comb begin
    query_pending = 1'b0;
    occ_off_s     = '0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      occ_off_s = PW'(i) - rd_ptr_q;
      if ((query_rd != '0) && ({1'b0, occ_off_s} < count_q) && (fifo_rd_q[i] == query_rd)) begin
        query_pending = 1'b1;
      end else begin
        query_pending = query_pending;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_writeback_arbiter
//   Directed testbench for rf_writeback_arbiter. A small regfile model captures
//   the DUT write port at every negedge so that register readback can be
//   checked against hand-computed values.
// -----------------------------------------------------------------------------
module tb_rf_writeback_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_rd;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] WriteData;
  logic [AW-1:0] WriteAddress;
  logic          RegWriteEn;
  logic [2:0]    fifo_count;
`ifdef WB_PENDING_EN
  logic [AW-1:0] query_rd;
  logic          query_pending;
`endif

  int n_checks;
  int n_fail;

  logic [DW-1:0] rf_model [32];

  rf_writeback_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_rd        (ld_rd),
    .ld_data      (ld_data),
    .WriteData    (WriteData),
    .WriteAddress (WriteAddress),
    .RegWriteEn   (RegWriteEn),
    .fifo_count   (fifo_count)
`ifdef WB_PENDING_EN
    ,
    .query_rd     (query_rd),
    .query_pending(query_pending)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile model: writes at negedge, as the real regfile does.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_model[i] <= '0;
    end else if (RegWriteEn && (WriteAddress != 5'd0)) begin
      rf_model[WriteAddress] <= WriteData;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    ld_valid  = 1'b0;
    ld_rd     = '0;
    ld_data   = '0;
`ifdef WB_PENDING_EN
    query_rd  = '0;
`endif
    repeat (3) step();
    rst = 1'b0;
    #1;
    check_eq("rst_wen",   RegWriteEn,   64'd0);
    check_eq("rst_cnt",   fifo_count,   64'd0);
    check_eq("rst_wdata", WriteData,    64'd0);
    check_eq("rst_waddr", WriteAddress, 64'd0);
    check_eq("rst_alurdy", alu_ready,   64'd1);
    check_eq("rst_ldrdy", ld_ready,     64'd1);

    // 1. ALU only
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 1'b0;
    check_eq("t1_wen",   RegWriteEn,   64'd1);
    check_eq("t1_waddr", WriteAddress, 64'd5);
    check_eq("t1_wdata", WriteData,    64'hDEADBEEF);
    step();
    check_eq("t1_idle_wen",  RegWriteEn,   64'd0);
    check_eq("t1_idle_hold", WriteAddress, 64'd5);
    check_eq("t1_rf5",       rf_model[5],  64'hDEADBEEF);

    // 2. x0 drop from the ALU
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    check_eq("t2_alurdy", alu_ready, 64'd1);
    step();
    alu_valid = 1'b0;
    check_eq("t2_wen", RegWriteEn, 64'd0);
    step();
    check_eq("t2_rf0", rf_model[0], 64'd0);

    // 3. Simultaneous ALU and load
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA;
    ld_valid  = 1'b1; ld_rd  = 5'd4; ld_data  = 32'hB;
    step();
    alu_valid = 1'b0; ld_valid = 1'b0;
    check_eq("t3_first_addr", WriteAddress, 64'd3);
    check_eq("t3_first_data", WriteData,    64'hA);
    check_eq("t3_cnt1",       fifo_count,   64'd1);
    step();
    check_eq("t3_second_wen",  RegWriteEn,   64'd1);
    check_eq("t3_second_addr", WriteAddress, 64'd4);
    check_eq("t3_second_data", WriteData,    64'hB);
    check_eq("t3_cnt0",        fifo_count,   64'd0);
    step();
    check_eq("t3_idle_wen", RegWriteEn, 64'd0);
    check_eq("t3_rf3", rf_model[3], 64'hA);
    check_eq("t3_rf4", rf_model[4], 64'hB);

    // x0 drop through the load FIFO
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h55;
    step();
    ld_valid = 1'b0;
    check_eq("x0ld_cnt1", fifo_count, 64'd1);
    step();
    check_eq("x0ld_wen",  RegWriteEn, 64'd0);
    check_eq("x0ld_cnt0", fifo_count, 64'd0);

    // 4. Starvation: one load, then continuous ALU traffic
    ld_valid  = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h101;
    step();
    ld_valid = 1'b0;
    check_eq("t4_alu1_addr", WriteAddress, 64'd1);
    for (int k = 0; k < 3; k++) begin
      alu_rd   = AW'(2 + k);
      alu_data = 32'h100 + DW'(2 + k);
      check_eq("t4_alurdy_wait", alu_ready, 64'd1);
      step();
      check_eq("t4_alu_addr", WriteAddress, 64'(2 + k));
    end
    alu_rd = 5'd5; alu_data = 32'h105;
    check_eq("t4_force_alurdy", alu_ready, 64'd0);
    step();
    check_eq("t4_ld_wen",  RegWriteEn,   64'd1);
    check_eq("t4_ld_addr", WriteAddress, 64'd7);
    check_eq("t4_ld_data", WriteData,    64'h77);
    check_eq("t4_cnt0",    fifo_count,   64'd0);
    check_eq("t4_alurdy_back", alu_ready, 64'd1);
    step();
    alu_valid = 1'b0;
    check_eq("t4_alu5_addr", WriteAddress, 64'd5);
    step();

    // 5. Full FIFO with ALU streaming
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h300;
    for (int k = 0; k < 4; k++) begin
      ld_valid = 1'b1; ld_rd = AW'(10 + k); ld_data = 32'h200 + DW'(k);
      check_eq("t5_alurdy_fill", alu_ready, 64'd1);
      step();
      check_eq("t5_alu_addr", WriteAddress, 64'd20);
    end
    ld_rd = 5'd15; ld_data = 32'h2FF;
    check_eq("t5_cnt4",   fifo_count, 64'd4);
    check_eq("t5_ldrdy",  ld_ready,   64'd0);
    check_eq("t5_alurdy", alu_ready,  64'd0);
    step();
    ld_valid = 1'b0; alu_valid = 1'b0;
    check_eq("t5_pop0_addr", WriteAddress, 64'd10);
    check_eq("t5_pop0_data", WriteData,    64'h200);
    check_eq("t5_cnt3",      fifo_count,   64'd3);
    for (int k = 1; k < 4; k++) begin
      step();
      check_eq("t5_pop_addr", WriteAddress, 64'(10 + k));
      check_eq("t5_pop_data", WriteData,    64'h200 + 64'(k));
      check_eq("t5_pop_wen",  RegWriteEn,   64'd1);
    end
    step();
    check_eq("t5_drained_wen", RegWriteEn, 64'd0);
    check_eq("t5_drained_cnt", fifo_count, 64'd0);

`ifdef WB_PENDING_EN
    // Pending query for a buffered load
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
    step();
    ld_valid = 1'b0;
    query_rd = 5'd9;
    #1;
    check_eq("pend_hit", query_pending, 64'd1);
    query_rd = 5'd8;
    #1;
    check_eq("pend_miss", query_pending, 64'd0);
    query_rd = 5'd9;
    step();
    check_eq("pend_after_pop", query_pending, 64'd0);
    query_rd = '0;
`endif

    // 6. Reset in the middle of operation
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h111;
    for (int k = 0; k < 3; k++) begin
      ld_valid = 1'b1; ld_rd = AW'(21 + k); ld_data = 32'h400 + DW'(k);
      step();
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    check_eq("t6_pre_cnt", fifo_count, 64'd3);
    check_eq("t6_pre_wen", RegWriteEn, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_rst_wen", RegWriteEn, 64'd0);
    check_eq("t6_rst_cnt", fifo_count, 64'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("t6_post_wen", RegWriteEn, 64'd0);
      check_eq("t6_post_cnt", fifo_count, 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
